// File: rtl/ub_pkg.sv
`default_nettype none
// ============================================================================
// Module : ub_pkg
// Brief  : Shared types and default sizing for the unified-buffer ring writer.
// Rev    : 1.0
// ============================================================================
package ub_pkg;

    localparam int UB_DATA_W      = 16;
    localparam int UB_DEPTH       = 128;
    localparam int UB_NUM_CH      = 2;
    localparam int UB_STALL_LIMIT = 64;

    typedef enum logic {
        SRC_VPU  = 1'b0,
        SRC_HOST = 1'b1
    } ub_src_e;

    typedef logic [UB_DATA_W-1:0] ub_data_t;

endpackage
`default_nettype wire

// File: rtl/ub_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module : ub_rr_arbiter
// Brief  : Two-requester round-robin grant, qualified by "beat fits" inputs.
// Rev    : 1.0
// ============================================================================
module ub_rr_arbiter
    import ub_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic req_vpu,
    input  logic req_host,
    input  logic fit_vpu,
    input  logic fit_host,
    output logic gnt_vpu,
    output logic gnt_host
);

    ub_src_e r_prio;
    logic    w_both;

    assign w_both = req_vpu & req_host;

    // Under contention only the priority source is considered, so a large
    // beat that does not fit blocks the other source instead of being bypassed.
    always_comb begin
        gnt_vpu  = 1'b0;
        gnt_host = 1'b0;
        if (rst) begin
            if (w_both) begin
                if (r_prio == SRC_VPU) gnt_vpu  = fit_vpu;
                else                   gnt_host = fit_host;
            end else begin
                gnt_vpu  = req_vpu  & fit_vpu;
                gnt_host = req_host & fit_host;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_prio <= SRC_VPU;
        end else if (w_both && (gnt_vpu || gnt_host)) begin
            r_prio <= (r_prio == SRC_VPU) ? SRC_HOST : SRC_VPU;
        end
    end

endmodule
`default_nettype wire

// File: rtl/ub_ring_writer.sv
`default_nettype none
// ============================================================================
// Module : ub_ring_writer
// Brief  : Two-writer ring buffer with in-place update port and in-order pop.
//          Stall watchdog built only when UB_STALL_WATCHDOG_EN is defined.
// Rev    : 1.0
// ============================================================================
module ub_ring_writer
    import ub_pkg::*;
#(
    parameter  int DATA_W      = UB_DATA_W,
    parameter  int DEPTH       = UB_DEPTH,
    parameter  int NUM_CH      = UB_NUM_CH,
    parameter  int STALL_LIMIT = UB_STALL_LIMIT,
    localparam int ADDR_W      = $clog2(DEPTH)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_CH-1:0]        vpu_valid,
    input  logic [NUM_CH*DATA_W-1:0] vpu_data,
    output logic                     vpu_ready,
    input  logic [NUM_CH-1:0]        host_valid,
    input  logic [NUM_CH*DATA_W-1:0] host_data,
    output logic                     host_ready,
    input  logic                     gd_valid,
    input  logic [ADDR_W-1:0]        gd_addr,
    input  logic [DATA_W-1:0]        gd_data,
    output logic                     gd_ready,
    output logic                     rd_valid,
    output logic [DATA_W-1:0]        rd_data,
    input  logic                     rd_ready,
    output logic [ADDR_W:0]          count,
    output logic                     full,
    output logic                     stall_detected
);

    localparam int                 c_CNT_W     = ADDR_W + 1;
    localparam logic [c_CNT_W-1:0] c_DEPTH_CNT = c_CNT_W'(DEPTH);

    logic [DATA_W-1:0]        r_mem [DEPTH];
    logic [ADDR_W-1:0]        r_wr_ptr;
    logic [ADDR_W-1:0]        r_rd_ptr;
    logic [c_CNT_W-1:0]       r_count;

    logic [c_CNT_W-1:0]       w_free;
    logic [c_CNT_W-1:0]       w_n_vpu;
    logic [c_CNT_W-1:0]       w_n_host;
    logic [c_CNT_W-1:0]       w_n_gnt;
    logic                     w_gnt_vpu;
    logic                     w_gnt_host;
    logic                     w_pop;
    logic [NUM_CH-1:0]        w_sel_valid;
    logic [NUM_CH*DATA_W-1:0] w_sel_data;
    logic [NUM_CH-1:0]        w_lane_we;
    logic [ADDR_W-1:0]        w_lane_addr [NUM_CH];
    logic [ADDR_W-1:0]        w_off;
    logic                     w_gd_hit;

    always_comb begin
        w_n_vpu  = '0;
        w_n_host = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            w_n_vpu  = w_n_vpu  + c_CNT_W'(vpu_valid[i]);
            w_n_host = w_n_host + c_CNT_W'(host_valid[i]);
        end
    end

    // Space freed by a same-cycle pop is deliberately not counted here.
    assign w_free = c_DEPTH_CNT - r_count;

    ub_rr_arbiter u_arb (
        .clk      (clk),
        .rst      (rst),
        .req_vpu  (|vpu_valid),
        .req_host (|host_valid),
        .fit_vpu  (w_n_vpu  <= w_free),
        .fit_host (w_n_host <= w_free),
        .gnt_vpu  (w_gnt_vpu),
        .gnt_host (w_gnt_host)
    );

    // Valid lanes are packed into consecutive slots starting at wr_ptr.
    always_comb begin
        w_sel_valid = '0;
        w_sel_data  = '0;
        w_n_gnt     = '0;
        if (w_gnt_vpu) begin
            w_sel_valid = vpu_valid;
            w_sel_data  = vpu_data;
            w_n_gnt     = w_n_vpu;
        end else if (w_gnt_host) begin
            w_sel_valid = host_valid;
            w_sel_data  = host_data;
            w_n_gnt     = w_n_host;
        end
        w_off    = '0;
        w_gd_hit = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
            w_lane_we[i]   = w_sel_valid[i];
            w_lane_addr[i] = r_wr_ptr + w_off;
            if (w_sel_valid[i]) w_off = w_off + ADDR_W'(1);
            if (w_lane_we[i] && (w_lane_addr[i] == gd_addr)) w_gd_hit = 1'b1;
        end
    end

    assign vpu_ready  = w_gnt_vpu;
    assign host_ready = w_gnt_host;
    assign gd_ready   = rst & ~w_gd_hit;
    assign rd_valid   = rst & (r_count != '0);
    assign full       = rst & (r_count == c_DEPTH_CNT);
    assign count      = r_count;
    assign rd_data    = r_mem[r_rd_ptr];
    assign w_pop      = rd_valid & rd_ready;

    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_CH; i++) begin
            if (w_lane_we[i]) r_mem[w_lane_addr[i]] <= w_sel_data[i*DATA_W +: DATA_W];
        end
        if (gd_valid && gd_ready) r_mem[gd_addr] <= gd_data;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            r_wr_ptr <= r_wr_ptr + w_n_gnt[ADDR_W-1:0];
            if (w_pop) r_rd_ptr <= r_rd_ptr + ADDR_W'(1);
            r_count  <= r_count + w_n_gnt - c_CNT_W'(w_pop);
        end
    end

`ifdef UB_STALL_WATCHDOG_EN
    localparam int                   c_STALL_W = $clog2(STALL_LIMIT + 1);
    localparam logic [c_STALL_W-1:0] c_LIMIT   = c_STALL_W'(STALL_LIMIT);

    logic [c_STALL_W-1:0] r_stall_cnt;
    logic [c_STALL_W-1:0] w_stall_cnt_nxt;
    logic                 r_stall;
    logic                 w_blocked;

    assign w_blocked = ((|vpu_valid)  & ~vpu_ready)
                     | ((|host_valid) & ~host_ready)
                     | (gd_valid      & ~gd_ready);

    always_comb begin
        w_stall_cnt_nxt = r_stall_cnt;
        if (!w_blocked)                w_stall_cnt_nxt = '0;
        else if (r_stall_cnt != c_LIMIT) w_stall_cnt_nxt = r_stall_cnt + c_STALL_W'(1);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_stall_cnt <= '0;
            r_stall     <= 1'b0;
        end else begin
            r_stall_cnt <= w_stall_cnt_nxt;
            if (w_stall_cnt_nxt == c_LIMIT) r_stall <= 1'b1;
        end
    end

    assign stall_detected = r_stall;
`else
    logic w_unused_limit;
    assign w_unused_limit = (STALL_LIMIT != 0);
    assign stall_detected = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_ub_ring_writer.sv
`default_nettype none
// ============================================================================
// Module : tb_ub_ring_writer
// Brief  : Directed self-checking bench for ub_ring_writer (default sizing).
// Rev    : 1.0
// ============================================================================
module tb_ub_ring_writer;

`ifdef UB_STALL_WATCHDOG_EN
    localparam logic c_EXP_STALL = 1'b1;
`else
    localparam logic c_EXP_STALL = 1'b0;
`endif

    logic        clk;
    logic        rst;
    logic [1:0]  vpu_valid;
    logic [31:0] vpu_data;
    logic        vpu_ready;
    logic [1:0]  host_valid;
    logic [31:0] host_data;
    logic        host_ready;
    logic        gd_valid;
    logic [6:0]  gd_addr;
    logic [15:0] gd_data;
    logic        gd_ready;
    logic        rd_valid;
    logic [15:0] rd_data;
    logic        rd_ready;
    logic [7:0]  count;
    logic        full;
    logic        stall_detected;

    int err_cnt = 0;
    int chk_cnt = 0;

    ub_ring_writer dut (
        .clk            (clk),
        .rst            (rst),
        .vpu_valid      (vpu_valid),
        .vpu_data       (vpu_data),
        .vpu_ready      (vpu_ready),
        .host_valid     (host_valid),
        .host_data      (host_data),
        .host_ready     (host_ready),
        .gd_valid       (gd_valid),
        .gd_addr        (gd_addr),
        .gd_data        (gd_data),
        .gd_ready       (gd_ready),
        .rd_valid       (rd_valid),
        .rd_data        (rd_data),
        .rd_ready       (rd_ready),
        .count          (count),
        .full           (full),
        .stall_detected (stall_detected)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        chk_cnt++;
        if (obs !== exp) begin
            err_cnt++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pop_chk(input string tag, input logic [15:0] exp);
        rd_ready = 1'b1;
        #1;
        chk({tag, "_valid"}, {31'd0, rd_valid}, 32'd1);
        chk(tag, {16'd0, rd_data}, {16'd0, exp});
        tick();
        rd_ready = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [15:0] exp_q [8];
        logic [15:0] e;
        logic [15:0] d;
        int          a;

        rst = 1'b0; vpu_valid = '0; vpu_data = '0; host_valid = '0; host_data = '0;
        gd_valid = 1'b0; gd_addr = '0; gd_data = '0; rd_ready = 1'b0;
        tick();
        tick();

        // Reset state: readies held low even with requests present
        vpu_valid = 2'b11;
        gd_valid  = 1'b1;
        #1;
        chk("rst_count", {24'd0, count}, 32'd0);
        chk("rst_rd_valid", {31'd0, rd_valid}, 32'd0);
        chk("rst_full", {31'd0, full}, 32'd0);
        chk("rst_stall", {31'd0, stall_detected}, 32'd0);
        chk("rst_vpu_ready", {31'd0, vpu_ready}, 32'd0);
        chk("rst_gd_ready", {31'd0, gd_ready}, 32'd0);
        vpu_valid = '0;
        gd_valid  = 1'b0;
        rst = 1'b1;
        tick();

        // Single full VPU beat
        vpu_valid = 2'b11;
        vpu_data  = {16'h0002, 16'h0001};
        #1;
        chk("t1_vpu_ready", {31'd0, vpu_ready}, 32'd1);
        tick();
        vpu_valid = '0;
        #1;
        chk("t1_count", {24'd0, count}, 32'd2);
        chk("t1_rd_data", {16'd0, rd_data}, 32'h0001);
        pop_chk("t1_pop0", 16'h0001);
        pop_chk("t1_pop1", 16'h0002);
        chk("t1_count_end", {24'd0, count}, 32'd0);

        // Both sources continuously: grants alternate starting with VPU
        for (int k = 0; k < 4; k++) begin
            vpu_valid  = 2'b11;
            host_valid = 2'b11;
            vpu_data   = {16'h1000 + 16'(2*k+1), 16'h1000 + 16'(2*k)};
            host_data  = {16'h2000 + 16'(2*k+1), 16'h2000 + 16'(2*k)};
            exp_q[2*k]   = ((k % 2) == 0) ? 16'h1000 + 16'(2*k)   : 16'h2000 + 16'(2*k);
            exp_q[2*k+1] = ((k % 2) == 0) ? 16'h1000 + 16'(2*k+1) : 16'h2000 + 16'(2*k+1);
            #1;
            chk("t2_vpu_ready", {31'd0, vpu_ready}, ((k % 2) == 0) ? 32'd1 : 32'd0);
            chk("t2_host_ready", {31'd0, host_ready}, ((k % 2) == 1) ? 32'd1 : 32'd0);
            tick();
        end
        vpu_valid  = '0;
        host_valid = '0;
        #1;
        chk("t2_count", {24'd0, count}, 32'd8);
        for (int k = 0; k < 8; k++) pop_chk("t2_pop", exp_q[k]);

        // Sparse lane mask: only lane 1 written, packed to wr_ptr
        vpu_valid = 2'b10;
        vpu_data  = {16'hBEEF, 16'hDEAD};
        #1;
        chk("t3_vpu_ready", {31'd0, vpu_ready}, 32'd1);
        tick();
        vpu_valid = '0;
        #1;
        chk("t3_count", {24'd0, count}, 32'd1);
        pop_chk("t3_pop", 16'hBEEF);
        chk("t3_count_end", {24'd0, count}, 32'd0);

        // Gradient update colliding with lane 0 append at address 11
        vpu_valid = 2'b11;
        vpu_data  = {16'h3333, 16'h3332};
        gd_valid  = 1'b1;
        gd_addr   = 7'd11;
        gd_data   = 16'hAAAA;
        #1;
        chk("t4_vpu_ready", {31'd0, vpu_ready}, 32'd1);
        chk("t4_gd_blocked", {31'd0, gd_ready}, 32'd0);
        tick();
        vpu_valid = '0;
        #1;
        chk("t4_gd_ready", {31'd0, gd_ready}, 32'd1);
        chk("t4_rd_before", {16'd0, rd_data}, 32'h3332);
        tick();
        gd_valid = 1'b0;
        #1;
        chk("t4_count", {24'd0, count}, 32'd2);
        pop_chk("t4_pop0", 16'hAAAA);
        pop_chk("t4_pop1", 16'h3333);

        // Advance both pointers from 13 to 0 (115 entries), then drain
        for (int k = 0; k < 57; k++) begin
            vpu_valid = 2'b11;
            vpu_data  = 32'h0;
            tick();
        end
        vpu_valid = 2'b01;
        tick();
        vpu_valid = '0;
        #1;
        chk("pad_count", {24'd0, count}, 32'd115);
        rd_ready = 1'b1;
        repeat (115) tick();
        rd_ready = 1'b0;
        #1;
        chk("pad_drained", {24'd0, count}, 32'd0);

        // Fill to 127 entries (addr a holds 0x4000+a), then a 2-lane beat must wait
        for (int k = 0; k < 63; k++) begin
            vpu_valid = 2'b11;
            vpu_data  = {16'h4000 + 16'(2*k+1), 16'h4000 + 16'(2*k)};
            tick();
        end
        vpu_valid = 2'b01;
        vpu_data  = {16'h0000, 16'h407E};
        tick();
        vpu_valid = 2'b11;
        vpu_data  = {16'h5001, 16'h5000};
        #1;
        chk("t5_count127", {24'd0, count}, 32'd127);
        chk("t5_not_full", {31'd0, full}, 32'd0);
        chk("t5_blocked", {31'd0, vpu_ready}, 32'd0);
        rd_ready = 1'b1;
        #1;
        chk("t5_blocked_pop", {31'd0, vpu_ready}, 32'd0);
        chk("t5_pop_data", {16'd0, rd_data}, 32'h4000);
        tick();
        rd_ready = 1'b0;
        #1;
        chk("t5_accept", {31'd0, vpu_ready}, 32'd1);
        tick();
        vpu_valid = '0;
        #1;
        chk("t5_count128", {24'd0, count}, 32'd128);
        chk("t5_full", {31'd0, full}, 32'd1);

        // Full buffer, host held off: watchdog trips on the 64th blocked cycle
        host_valid = 2'b11;
        host_data  = {16'h6001, 16'h6000};
        #1;
        chk("t6_host_blocked", {31'd0, host_ready}, 32'd0);
        repeat (63) tick();
        chk("t6_stall_63", {31'd0, stall_detected}, 32'd0);
        tick();
        chk("t6_stall_64", {31'd0, stall_detected}, {31'd0, c_EXP_STALL});
        host_valid = '0;

        // Drain in order across the wrap: 1..126, then 127 and 0
        for (int i = 0; i < 128; i++) begin
            a = (1 + i) % 128;
            if (a == 127)    e = 16'h5000;
            else if (a == 0) e = 16'h5001;
            else begin
                d = 16'(a);
                e = 16'h4000 + d;
            end
            pop_chk("t6_drain", e);
        end
        #1;
        chk("t6_count_end", {24'd0, count}, 32'd0);
        chk("t6_rd_valid_end", {31'd0, rd_valid}, 32'd0);
        chk("t6_stall_sticky", {31'd0, stall_detected}, {31'd0, c_EXP_STALL});

        // Reset clears the sticky flag
        rst = 1'b0;
        tick();
        chk("t7_stall_cleared", {31'd0, stall_detected}, 32'd0);
        chk("t7_count", {24'd0, count}, 32'd0);

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

endmodule
`default_nettype wire
